axis_dest_router: RTL and testbench
===================================

# axis_dest_router

Parametrised AXI4-Stream 1-to-N router that steers whole packets from one slave port to one of `NUM_M` master ports, selected by TDEST. It replaces the fixed 8-bit, three-output interconnect instance in the stream link path. It adds:
- packet-level route locking;
- a registered output stage per port;
- explicit handling of out-of-range destinations.

## Interface
Parameters:
- `DATA_W`, 8, TDATA width in bits; multiple of 8, range 8..512.
- `NUM_M`, 3, number of master ports, range 1..16.
- `DEST_W`, 2, TDEST width; must satisfy 2^`DEST_W` >= `NUM_M`.

Ports:
- `s_axis_aclk` input 1: single clock for all logic.
- `s_axis_areset` input 1: synchronous, active-high reset.
- `s_axis_tready` output 1: slave ready.
- `s_axis_tvalid` input 1: slave valid.
- `s_axis_tdata` input `DATA_W`: slave data.
- `s_axis_tkeep` input `DATA_W/8`: slave byte keep.
- `s_axis_tlast` input 1: end of packet.
- `s_axis_tdest` input `DEST_W`: destination port index.
- `m_axis_tready` input `NUM_M`: per-port ready; bit i belongs to port i.
- `m_axis_tvalid` output `NUM_M`: per-port valid.
- `m_axis_tdata` output `NUM_M*DATA_W`: flattened data; port i occupies `[i*DATA_W +: DATA_W]`.
- `m_axis_tkeep` output `NUM_M*DATA_W/8`: flattened keep.
- `m_axis_tlast` output `NUM_M`: per-port last.
- `m_axis_tdest` output `NUM_M*DEST_W`: the captured TDEST, forwarded unchanged.
- `decode_err` output 1: one-cycle pulse on the first beat of a packet whose TDEST is >= `NUM_M`.

## Operation
- Route FSM states: `IDLE`, `ROUTE`, `DROP`.
- `IDLE`: the beat at the slave is a packet head.
  - Target port = `s_axis_tdest` if `s_axis_tdest` < `NUM_M`; otherwise the behaviour is set by the Configuration section.
  - If the head beat is accepted with tlast=0, the FSM moves to `ROUTE` (valid target) or `DROP` (invalid target), and the target index is latched into `route_sel`.
  - If the head beat has tlast=1 (single-beat packet), the FSM stays in `IDLE`.
- `ROUTE`: every beat goes to `route_sel`; `s_axis_tdest` is ignored until the packet ends. An accepted beat with tlast=1 returns the FSM to `IDLE`.
- `DROP`: beats are consumed and discarded. An accepted beat with tlast=1 returns the FSM to `IDLE`.
- Each port has a one-entry output register holding tvalid/tdata/tkeep/tlast/tdest.
  - The register loads on an accepted beat routed to that port.
  - It clears tvalid when it drains (tvalid & tready) and no new beat is loaded in the same cycle.
- `s_axis_tready` = !reset & (dropping | !m_tvalid[sel] | m_tready[sel]). This is a combinational path from `m_axis_tready` to `s_axis_tready`; that path is accepted by design.
- Head-of-line blocking is accepted: a stalled target stalls the slave. Ports other than the target are never affected.

## Timing
- Reset values:
  - all `m_axis_tvalid` = 0;
  - `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tdest` = 0;
  - `decode_err` = 0;
  - FSM = `IDLE`;
  - `s_axis_tready` = 0 while `s_axis_areset` = 1.
- Latency: a beat accepted at edge N is on the master port after edge N, i.e. visible from cycle N+1.
- Throughput: 1 beat/cycle sustained while the target's `m_axis_tready` = 1.
- Simultaneous drain and load on the same port in one cycle: the new beat replaces the old one and tvalid stays 1.
- `decode_err` is asserted the cycle after the accepted head beat, for exactly one cycle per bad packet.
- Reset mid-packet: buffered beats are lost and the FSM returns to `IDLE`. The next accepted beat is treated as a packet head.
- `s_axis_tvalid` = 0 in any state: no state change and no output change apart from drains.

## Configuration
- `AXIS_ROUTER_DROP_EN` defined:
  - Packets with TDEST >= `NUM_M` enter `DROP`.
  - `s_axis_tready` = 1 for all their beats.
  - No master port sees any of their beats.
  - `decode_err` pulses once per such packet.
- Not defined:
  - An out-of-range TDEST routes the packet to port `NUM_M-1`, with TDEST forwarded unchanged.
  - `decode_err` still pulses, and the `DROP` state is not synthesised.

## Test plan
- Defaults; 4-beat packet 0x11..0x14 with tdest=1, m_tready all 1 → port 1 emits 0x11..0x14 on consecutive cycles with tlast on 0x14; ports 0 and 2 tvalid stay 0; first output 1 cycle after first accept.
- tdest changes 1→2 on beat 3 of a 4-beat packet → all 4 beats appear on port 1; the next packet with tdest=2 goes to port 2.
- Port 0 m_tready=0 for 5 cycles during a tdest=0 packet → s_tready=0 after the first beat buffers; no beat lost or duplicated; port 0 resumes 1 beat/cycle once ready=1.
- tdest=3 (`NUM_M`=3), 3-beat packet:
  - with `AXIS_ROUTER_DROP_EN` → s_tready=1 for all 3 beats, no master tvalid, one `decode_err` pulse;
  - without → packet appears on port 2, one `decode_err` pulse.
- Back-to-back single-beat packets to ports 0, 1, 2, 0 → each beat on its own port in order, one beat per cycle.
- Reset asserted on beat 2 of 4, then a fresh tdest=2 packet → all tvalid 0 in the cycle after reset; the new packet's first beat goes to port 2.

Source files
------------

// File: rtl/axis_dest_router_if.sv
// Bundled slave-side and master-side AXI4-Stream signals of axis_dest_router.
// The slave modport is the router's view; the master modport is the surrounding fabric.
interface axis_dest_router_if #(
    parameter int DATA_W = 8,
    parameter int NUM_M  = 3,
    parameter int DEST_W = 2
) ();
    logic                         s_axis_tready;
    logic                         s_axis_tvalid;
    logic [DATA_W-1:0]            s_axis_tdata;
    logic [DATA_W/8-1:0]          s_axis_tkeep;
    logic                         s_axis_tlast;
    logic [DEST_W-1:0]            s_axis_tdest;
    logic [NUM_M-1:0]             m_axis_tready;
    logic [NUM_M-1:0]             m_axis_tvalid;
    logic [NUM_M*DATA_W-1:0]      m_axis_tdata;
    logic [NUM_M*DATA_W/8-1:0]    m_axis_tkeep;
    logic [NUM_M-1:0]             m_axis_tlast;
    logic [NUM_M*DEST_W-1:0]      m_axis_tdest;

    modport slave (
        output s_axis_tready,
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest,
        input  m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest
    );

    modport master (
        input  s_axis_tready,
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tdest,
        output m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest
    );
endinterface

// File: rtl/axis_dest_router.sv
// AXI4-Stream 1-to-NUM_M packet router steered by TDEST, one output register per port.
// Define AXIS_ROUTER_DROP_EN to discard packets whose TDEST >= NUM_M instead of sending them to the last port.
module axis_dest_router #(
    parameter int DATA_W = 8,
    parameter int NUM_M  = 3,
    parameter int DEST_W = 2
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    axis_dest_router_if.slave bus,
    output logic              decode_err
);
    localparam int                KEEP_W    = DATA_W / 8;
    localparam logic [DEST_W:0]   NUM_M_EXT = (DEST_W + 1)'(NUM_M);
    localparam logic [DEST_W-1:0] LAST_PORT = DEST_W'(NUM_M - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DEST_W-1:0]       route_sel_q, route_sel_d;
    logic                    decode_err_q, decode_err_d;
    logic [NUM_M-1:0]        m_tvalid_q, m_tvalid_d;
    logic [NUM_M*DATA_W-1:0] m_tdata_q, m_tdata_d;
    logic [NUM_M*KEEP_W-1:0] m_tkeep_q, m_tkeep_d;
    logic [NUM_M-1:0]        m_tlast_q, m_tlast_d;
    logic [NUM_M*DEST_W-1:0] m_tdest_q, m_tdest_d;

    logic                    is_head_s, dest_ok_s, head_drop_s, drop_s;
    logic                    tgt_ready_s, s_tready_s, accept_s;
    logic [DEST_W-1:0]       head_sel_s, sel_s;

    // Target selection: head beats decode TDEST, body beats follow the locked route.
    always_comb begin
        is_head_s = (state_q == ST_IDLE);
        dest_ok_s = ({1'b0, bus.s_axis_tdest} < NUM_M_EXT);
        if (dest_ok_s) begin
            head_sel_s = bus.s_axis_tdest;
        end else begin
            head_sel_s = LAST_PORT;
        end
`ifdef AXIS_ROUTER_DROP_EN
        head_drop_s = !dest_ok_s;
`else
        head_drop_s = 1'b0;
`endif
        if (is_head_s) begin
            sel_s  = head_sel_s;
            drop_s = head_drop_s;
        end else begin
            sel_s  = route_sel_q;
            drop_s = (state_q == ST_DROP);
        end
        tgt_ready_s = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            tgt_ready_s = tgt_ready_s |
                ((sel_s == DEST_W'(i)) & (!m_tvalid_q[i] | bus.m_axis_tready[i]));
        end
        s_tready_s = !s_axis_areset && (drop_s || tgt_ready_s);
        accept_s   = bus.s_axis_tvalid && s_tready_s;
    end

    // Route FSM next state, route lock and decode error pulse.
    always_comb begin
        state_d      = state_q;
        route_sel_d  = route_sel_q;
        decode_err_d = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    route_sel_d  = head_sel_s;
                    decode_err_d = !dest_ok_s;
                    if (bus.s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end else if (head_drop_s) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_ROUTE;
                    end
                end
                ST_ROUTE, ST_DROP: begin
                    if (bus.s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Per-port output registers: drain on ready, a new load wins over a drain.
    always_comb begin
        m_tvalid_d = m_tvalid_q & ~bus.m_axis_tready;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tdest_d  = m_tdest_q;
        for (int i = 0; i < NUM_M; i++) begin
            if (accept_s && !drop_s && (sel_s == DEST_W'(i))) begin
                m_tvalid_d[i]                  = 1'b1;
                m_tdata_d[i*DATA_W +: DATA_W]  = bus.s_axis_tdata;
                m_tkeep_d[i*KEEP_W +: KEEP_W]  = bus.s_axis_tkeep;
                m_tlast_d[i]                   = bus.s_axis_tlast;
                m_tdest_d[i*DEST_W +: DEST_W]  = bus.s_axis_tdest;
            end else begin
                m_tvalid_d[i] = m_tvalid_d[i];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q      <= ST_IDLE;
            route_sel_q  <= {DEST_W{1'b0}};
            decode_err_q <= 1'b0;
            m_tvalid_q   <= {NUM_M{1'b0}};
            m_tdata_q    <= {(NUM_M*DATA_W){1'b0}};
            m_tkeep_q    <= {(NUM_M*KEEP_W){1'b0}};
            m_tlast_q    <= {NUM_M{1'b0}};
            m_tdest_q    <= {(NUM_M*DEST_W){1'b0}};
        end else begin
            state_q      <= state_d;
            route_sel_q  <= route_sel_d;
            decode_err_q <= decode_err_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tlast_q    <= m_tlast_d;
            m_tdest_q    <= m_tdest_d;
        end
    end

    assign bus.s_axis_tready = s_tready_s;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tkeep  = m_tkeep_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign bus.m_axis_tdest  = m_tdest_q;
    assign decode_err        = decode_err_q;
endmodule

// File: tb/tb_axis_dest_router.sv
// Table-driven bench for axis_dest_router (defaults: 8-bit data, 3 ports, 2-bit dest),
// plus a hand-written mid-packet reset sequence.
module tb_axis_dest_router;
    localparam int DATA_W = 8;
    localparam int NUM_M  = 3;
    localparam int DEST_W = 2;

    logic clk;
    logic rst;
    logic decode_err;
    int   checks;
    int   errors;

    axis_dest_router_if #(.DATA_W(DATA_W), .NUM_M(NUM_M), .DEST_W(DEST_W)) bus ();

    axis_dest_router #(.DATA_W(DATA_W), .NUM_M(NUM_M), .DEST_W(DEST_W)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .bus           (bus),
        .decode_err    (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        s_valid;
        logic [7:0]  s_data;
        logic        s_last;
        logic [1:0]  s_dest;
        logic [2:0]  m_ready;
        logic        exp_s_ready;
        logic [2:0]  exp_valid;
        logic [23:0] exp_data;
        logic [2:0]  exp_last;
        logic [5:0]  exp_dest;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic v, input logic [7:0] d,
                                input logic l, input logic [1:0] de, input logic [2:0] mr,
                                input logic sr, input logic [2:0] ev, input logic [23:0] ed,
                                input logic [2:0] el, input logic [5:0] edst, input logic ee);
        vec_t t;
        t.name = nm; t.s_valid = v; t.s_data = d; t.s_last = l; t.s_dest = de; t.m_ready = mr;
        t.exp_s_ready = sr; t.exp_valid = ev; t.exp_data = ed; t.exp_last = el;
        t.exp_dest = edst; t.exp_err = ee;
        vecs.push_back(t);
    endfunction

    task automatic drive(input logic v, input logic [7:0] d, input logic l,
                         input logic [1:0] de, input logic [2:0] mr);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = d;
        bus.s_axis_tkeep  = 1'b1;
        bus.s_axis_tlast  = l;
        bus.s_axis_tdest  = de;
        bus.m_axis_tready = mr;
    endtask

    // Compare only the fields of ports whose tvalid is expected high.
    task automatic check_out(input string nm, input logic [2:0] ev, input logic [23:0] ed,
                             input logic [2:0] el, input logic [5:0] edst, input logic ee);
        logic [23:0] dmask;
        logic [5:0]  tmask;
        for (int p = 0; p < 3; p++) begin
            dmask[p*8 +: 8] = {8{ev[p]}};
            tmask[p*2 +: 2] = {2{ev[p]}};
        end
        check({nm, ".valid"}, 32'(bus.m_axis_tvalid), 32'(ev));
        check({nm, ".data"},  32'(bus.m_axis_tdata & dmask), 32'(ed));
        check({nm, ".keep"},  32'(bus.m_axis_tkeep & ev), 32'(ev));
        check({nm, ".last"},  32'(bus.m_axis_tlast & ev), 32'(el));
        check({nm, ".dest"},  32'(bus.m_axis_tdest & tmask), 32'(edst));
        check({nm, ".err"},   32'(decode_err), 32'(ee));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b1, 8'hAA, 1'b0, 2'd0, 3'b111);
        repeat (3) @(posedge clk);
        #1;
        check("rst.s_ready", 32'(bus.s_axis_tready), 32'd0);
        check("rst.valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst.data",  32'(bus.m_axis_tdata), 32'd0);
        check("rst.keep",  32'(bus.m_axis_tkeep), 32'd0);
        check("rst.last",  32'(bus.m_axis_tlast), 32'd0);
        check("rst.dest",  32'(bus.m_axis_tdest), 32'd0);
        check("rst.err",   32'(decode_err), 32'd0);
        rst = 1'b0;

        // 4-beat packet to port 1
        add("p1b0", 1'b1, 8'h11, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'h001100, 3'b000, 6'b000100, 1'b0);
        add("p1b1", 1'b1, 8'h12, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'h001200, 3'b000, 6'b000100, 1'b0);
        add("p1b2", 1'b1, 8'h13, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'h001300, 3'b000, 6'b000100, 1'b0);
        add("p1b3", 1'b1, 8'h14, 1'b1, 2'd1, 3'b111, 1'b1, 3'b010, 24'h001400, 3'b010, 6'b000100, 1'b0);
        add("idl1", 1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
        // TDEST changes mid-packet: route stays locked on port 1
        add("lkb0", 1'b1, 8'h21, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'h002100, 3'b000, 6'b000100, 1'b0);
        add("lkb1", 1'b1, 8'h22, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'h002200, 3'b000, 6'b000100, 1'b0);
        add("lkb2", 1'b1, 8'h23, 1'b0, 2'd2, 3'b111, 1'b1, 3'b010, 24'h002300, 3'b000, 6'b001000, 1'b0);
        add("lkb3", 1'b1, 8'h24, 1'b1, 2'd1, 3'b111, 1'b1, 3'b010, 24'h002400, 3'b010, 6'b000100, 1'b0);
        add("nxt2", 1'b1, 8'h31, 1'b1, 2'd2, 3'b111, 1'b1, 3'b100, 24'h310000, 3'b100, 6'b100000, 1'b0);
        // back-to-back single-beat packets to ports 0,1,2,0
        add("sb0",  1'b1, 8'h41, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 24'h000041, 3'b001, 6'b000000, 1'b0);
        add("sb1",  1'b1, 8'h42, 1'b1, 2'd1, 3'b111, 1'b1, 3'b010, 24'h004200, 3'b010, 6'b000100, 1'b0);
        add("sb2",  1'b1, 8'h43, 1'b1, 2'd2, 3'b111, 1'b1, 3'b100, 24'h430000, 3'b100, 6'b100000, 1'b0);
        add("sb3",  1'b1, 8'h44, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 24'h000044, 3'b001, 6'b000000, 1'b0);
        add("idl2", 1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
        // port 0 stalled for 5 cycles mid-packet
        add("st0",  1'b1, 8'h51, 1'b0, 2'd0, 3'b110, 1'b1, 3'b001, 24'h000051, 3'b000, 6'b000000, 1'b0);
        add("st1",  1'b1, 8'h52, 1'b0, 2'd0, 3'b110, 1'b0, 3'b001, 24'h000051, 3'b000, 6'b000000, 1'b0);
        add("st2",  1'b1, 8'h52, 1'b0, 2'd0, 3'b110, 1'b0, 3'b001, 24'h000051, 3'b000, 6'b000000, 1'b0);
        add("st3",  1'b1, 8'h52, 1'b0, 2'd0, 3'b110, 1'b0, 3'b001, 24'h000051, 3'b000, 6'b000000, 1'b0);
        add("st4",  1'b1, 8'h52, 1'b0, 2'd0, 3'b110, 1'b0, 3'b001, 24'h000051, 3'b000, 6'b000000, 1'b0);
        add("st5",  1'b1, 8'h52, 1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 24'h000052, 3'b000, 6'b000000, 1'b0);
        add("st6",  1'b1, 8'h53, 1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 24'h000053, 3'b000, 6'b000000, 1'b0);
        add("st7",  1'b1, 8'h54, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 24'h000054, 3'b001, 6'b000000, 1'b0);
        add("idl3", 1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
        // out-of-range TDEST = 3
`ifdef AXIS_ROUTER_DROP_EN
        add("bad0", 1'b1, 8'h61, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b1);
        add("bad1", 1'b1, 8'h62, 1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
        add("bad2", 1'b1, 8'h63, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
`else
        add("bad0", 1'b1, 8'h61, 1'b0, 2'd3, 3'b111, 1'b1, 3'b100, 24'h610000, 3'b000, 6'b110000, 1'b1);
        add("bad1", 1'b1, 8'h62, 1'b0, 2'd3, 3'b111, 1'b1, 3'b100, 24'h620000, 3'b000, 6'b110000, 1'b0);
        add("bad2", 1'b1, 8'h63, 1'b1, 2'd3, 3'b111, 1'b1, 3'b100, 24'h630000, 3'b100, 6'b110000, 1'b0);
`endif
        add("idl4", 1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);
        add("aft",  1'b1, 8'h71, 1'b1, 2'd1, 3'b111, 1'b1, 3'b010, 24'h007100, 3'b010, 6'b000100, 1'b0);
        add("idl5", 1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].s_valid, vecs[i].s_data, vecs[i].s_last, vecs[i].s_dest, vecs[i].m_ready);
            #1;
            check({vecs[i].name, ".s_ready"}, 32'(bus.s_axis_tready), 32'(vecs[i].exp_s_ready));
            @(posedge clk);
            #1;
            check_out(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_last,
                      vecs[i].exp_dest, vecs[i].exp_err);
        end

        // reset on beat 2 of a port-1 packet, then a fresh port-2 packet
        drive(1'b1, 8'h81, 1'b0, 2'd1, 3'b111);
        #1;
        check("mr0.s_ready", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk);
        #1;
        check_out("mr0", 3'b010, 24'h008100, 3'b000, 6'b000100, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h82, 1'b0, 2'd1, 3'b111);
        #1;
        check("mr1.s_ready", 32'(bus.s_axis_tready), 32'd0);
        @(posedge clk);
        #1;
        check("mr1.valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("mr1.err", 32'(decode_err), 32'd0);
        rst = 1'b0;
        drive(1'b1, 8'h91, 1'b0, 2'd2, 3'b111);
        #1;
        check("mr2.s_ready", 32'(bus.s_axis_tready), 32'd1);
        @(posedge clk);
        #1;
        check_out("mr2", 3'b100, 24'h910000, 3'b000, 6'b100000, 1'b0);
        drive(1'b1, 8'h92, 1'b1, 2'd2, 3'b111);
        @(posedge clk);
        #1;
        check_out("mr3", 3'b100, 24'h920000, 3'b100, 6'b100000, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
        @(posedge clk);
        #1;
        check_out("mr4", 3'b000, 24'h000000, 3'b000, 6'b000000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
